// File: rtl/sram_pkg.sv
// Shared definitions for the SPI-to-SRAM logger: writer states, bus constants
// and small constant helpers.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam logic [3:0]  BS_ALL_OFF  = 4'hF;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_SETUP = 2'd1,
    WR_WRITE = 2'd2,
    WR_HOLD  = 2'd3
  } wr_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Active-low byte-select mask for a word holding cnt bytes: lanes at or
  // above cnt were never filled and stay disabled.
  function automatic logic [3:0] lane_mask(input logic [2:0] cnt);
    logic [3:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[i] = (i >= 32'(cnt));
    end
    return m;
  endfunction

endpackage

// File: rtl/spi_sram_logger_if.sv
// Async SRAM write-side bus: address, data, pad enable and active-low strobes.
interface spi_sram_logger_if
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W
);
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_dout;
  logic              sram_d_oe;
  logic [3:0]        sram_bs_n;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic              sram_oe_n;

  modport master (
    output sram_addr, sram_dout, sram_d_oe, sram_bs_n,
           sram_ce_n, sram_we_n, sram_oe_n
  );

  modport slave (
    input sram_addr, sram_dout, sram_d_oe, sram_bs_n,
          sram_ce_n, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/sram_write_ctrl.sv
// Async SRAM write-cycle sequencer: latches a word and lane mask on start,
// then runs SETUP -> WRITE -> HOLD with one shared phase down-counter.
// All bus outputs are registered and derived from the next state.
module sram_write_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned WE_CYCLES    = 3,
  parameter int unsigned HOLD_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] word,
  input  logic [3:0]  mask,
  output logic [31:0] dout,
  output logic [3:0]  bs_n,
  output logic        ce_n,
  output logic        we_n,
  output logic        d_oe,
  output logic        busy,
  output logic        done
);

  localparam int unsigned MAX_C = max3(SETUP_CYCLES, WE_CYCLES, HOLD_CYCLES);
  localparam int unsigned PH_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [PH_W-1:0] SETUP_LD = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] WE_LD    = PH_W'(WE_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LD  = PH_W'(HOLD_CYCLES - 1);

  wr_state_e       state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [31:0]     dout_q, dout_d;
  logic [3:0]      bs_n_q, bs_n_d;
  logic            ce_n_q, ce_n_d;
  logic            we_n_q, we_n_d;
  logic            d_oe_q, d_oe_d;

  // Next-state, phase reload and registered bus strobes.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dout_d  = dout_q;
    bs_n_d  = bs_n_q;
    unique case (state_q)
      WR_IDLE: begin
        if (start) begin
          state_d = WR_SETUP;
          phase_d = SETUP_LD;
          dout_d  = word;
          bs_n_d  = mask;
        end
      end
      WR_SETUP: begin
        if (phase_q == '0) begin
          state_d = WR_WRITE;
          phase_d = WE_LD;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      WR_WRITE: begin
        if (phase_q == '0) begin
          state_d = WR_HOLD;
          phase_d = HOLD_LD;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      WR_HOLD: begin
        if (phase_q == '0) begin
          state_d = WR_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      default: begin
        state_d = WR_IDLE;
        phase_d = '0;
      end
    endcase
    ce_n_d = (state_d == WR_IDLE);
    we_n_d = (state_d != WR_WRITE);
    d_oe_d = (state_d != WR_IDLE);
    if (state_d == WR_IDLE) bs_n_d = BS_ALL_OFF;
  end

  // State and bus registers, synchronous reset to an idle bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WR_IDLE;
      phase_q <= '0;
      dout_q  <= '0;
      bs_n_q  <= BS_ALL_OFF;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      d_oe_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dout_q  <= dout_d;
      bs_n_q  <= bs_n_d;
      ce_n_q  <= ce_n_d;
      we_n_q  <= we_n_d;
      d_oe_q  <= d_oe_d;
    end
  end

  assign dout = dout_q;
  assign bs_n = bs_n_q;
  assign ce_n = ce_n_q;
  assign we_n = we_n_q;
  assign d_oe = d_oe_q;
  assign busy = (state_q != WR_IDLE);
  assign done = (state_q == WR_HOLD) && (phase_q == '0);

endmodule

// File: rtl/spi_sram_logger.sv
// SPI byte stream to async SRAM logger: packs bytes little-endian into
// 32-bit words (with flush of partial words), double-buffers one pending
// word against the running write cycle, and tracks address/full/count.
module spi_sram_logger
  import sram_pkg::*;
#(
  parameter int unsigned       ADDR_W       = SRAM_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_W-1:0] LAST_ADDR    = '1,
  parameter int unsigned       SETUP_CYCLES = 1,
  parameter int unsigned       WE_CYCLES    = 3,
  parameter int unsigned       HOLD_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  flush,
  spi_sram_logger_if.master     sram,
  output logic                  full,
  output logic [ADDR_W:0]       words_written
);

  logic [31:0]       pack_q, pack_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [3:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic [ADDR_W:0]   ww_q, ww_d;
  logic              ready_q, ready_d;

  logic              accept;
  logic              wr_start;
  logic              wr_busy;
  logic              wr_done;
  logic              busy_next;
  logic [31:0]       wr_dout;
  logic [3:0]        wr_bs_n;
  logic              wr_ce_n;
  logic              wr_we_n;
  logic              wr_d_oe;

  // Packer, flush, hand-off and address/full bookkeeping. Order matters:
  // hand-off frees the pack register first, then a byte lands, then flush
  // sees the updated count, and a HOLD exit at LAST_ADDR discards all.
  always_comb begin
    pack_d   = pack_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    full_d   = full_q;
    ww_d     = ww_q;
    wr_start = 1'b0;
    accept   = byte_valid && ready_q;

    if (pend_q && !wr_busy && !full_q) begin
      wr_start = 1'b1;
      pend_d   = 1'b0;
      cnt_d    = '0;
      pack_d   = '0;
    end

    if (accept) begin
      pack_d[{cnt_d[1:0], 3'b000} +: 8] = byte_data;
      cnt_d = cnt_d + 3'd1;
      if (cnt_d == 3'd4) begin
        pend_d = 1'b1;
        mask_d = '0;
      end
    end

    if (flush && !full_q && !pend_d && (cnt_d != '0)) begin
      pend_d = 1'b1;
      mask_d = lane_mask(cnt_d);
    end

    if (wr_done) begin
      ww_d = ww_q + (ADDR_W+1)'(1);
      if (addr_q == LAST_ADDR) begin
        full_d = 1'b1;
        pend_d = 1'b0;
        cnt_d  = '0;
        pack_d = '0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end

    // Ready is registered from next-cycle state so byte_valid never reaches it.
    busy_next = wr_start || (wr_busy && !wr_done);
    ready_d   = !full_d && !(pend_d && busy_next);
  end

  // Logger state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pack_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      mask_q  <= BS_ALL_OFF;
      addr_q  <= BASE_ADDR;
      full_q  <= 1'b0;
      ww_q    <= '0;
      ready_q <= 1'b1;
    end else begin
      pack_q  <= pack_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      ww_q    <= ww_d;
      ready_q <= ready_d;
    end
  end

  sram_write_ctrl #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .WE_CYCLES    (WE_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) u_wr (
    .clk   (clk),
    .reset (reset),
    .start (wr_start),
    .word  (pack_q),
    .mask  (mask_q),
    .dout  (wr_dout),
    .bs_n  (wr_bs_n),
    .ce_n  (wr_ce_n),
    .we_n  (wr_we_n),
    .d_oe  (wr_d_oe),
    .busy  (wr_busy),
    .done  (wr_done)
  );

  assign sram.sram_addr = addr_q;
  assign sram.sram_dout = wr_dout;
  assign sram.sram_d_oe = wr_d_oe;
  assign sram.sram_bs_n = wr_bs_n;
  assign sram.sram_ce_n = wr_ce_n;
  assign sram.sram_we_n = wr_we_n;
  assign sram.sram_oe_n = 1'b1;

  assign byte_ready    = ready_q;
  assign full          = full_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_spi_sram_logger.sv
// Self-checking bench for spi_sram_logger: table of single-word cases, a
// scoreboard fed by a transaction-level byte packer, and hand-written
// streaming / full / reset-mid-write sequences.
module tb_spi_sram_logger;
  import sram_pkg::*;

  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          flush;
  logic          ready_a, ready_b;
  logic          full_a, full_b;
  logic [AW:0]   ww_a, ww_b;

  always #5 clk = ~clk;

  spi_sram_logger_if #(.ADDR_W(AW)) sif_a ();
  spi_sram_logger_if #(.ADDR_W(AW)) sif_b ();

  // Main DUT: large enough address range that the tests never fill it.
  spi_sram_logger #(
    .ADDR_W(AW), .BASE_ADDR(18'd0), .LAST_ADDR(18'd15),
    .SETUP_CYCLES(1), .WE_CYCLES(3), .HOLD_CYCLES(1)
  ) dut_a (
    .clk(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(ready_a), .flush(flush), .sram(sif_a.master),
    .full(full_a), .words_written(ww_a)
  );

  // Second DUT on the same stimulus with a 4-word space for the full test.
  spi_sram_logger #(
    .ADDR_W(AW), .BASE_ADDR(18'd0), .LAST_ADDR(18'd3),
    .SETUP_CYCLES(1), .WE_CYCLES(3), .HOLD_CYCLES(1)
  ) dut_b (
    .clk(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(ready_b), .flush(flush), .sram(sif_b.master),
    .full(full_b), .words_written(ww_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] bs);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (!bs[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // ---------------- scoreboard and byte-level model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    bs;
  } exp_t;

  exp_t        sb[$];
  int          m_cnt  = 0;
  logic [31:0] m_word = '0;
  int          m_addr = 0;
  int          stall_cnt = 0;

  task automatic m_push(input logic [3:0] bs);
    exp_t e;
    e.addr = AW'(m_addr);
    e.data = m_word;
    e.bs   = bs;
    sb.push_back(e);
    m_addr++;
    m_cnt  = 0;
    m_word = '0;
  endtask

  task automatic m_accept(input logic [7:0] b);
    m_word[8*m_cnt +: 8] = b;
    m_cnt++;
    if (m_cnt == 4) m_push(4'b0000);
  endtask

  task automatic m_flush();
    logic [3:0] bs;
    if (m_cnt != 0) begin
      for (int i = 0; i < 4; i++) bs[i] = (i >= m_cnt);
      m_push(bs);
    end
  endtask

  // ---------------- SRAM bus monitor on dut_a ----------------
  logic          in_win = 1'b0;
  int            ce_cnt, we_cnt;
  bit            stable_ok;
  logic [AW-1:0] cap_addr;
  logic [31:0]   cap_dout;
  logic [3:0]    cap_bs;
  int            n_writes = 0;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_dout;
  logic [3:0]    last_bs;

  always @(negedge clk) begin
    if (reset) begin
      in_win = 1'b0;
    end else if (!sif_a.sram_ce_n) begin
      if (!in_win) begin
        in_win    = 1'b1;
        ce_cnt    = 0;
        we_cnt    = 0;
        stable_ok = 1'b1;
        cap_addr  = sif_a.sram_addr;
        cap_dout  = sif_a.sram_dout;
        cap_bs    = sif_a.sram_bs_n;
      end
      if (sif_a.sram_addr !== cap_addr || sif_a.sram_dout !== cap_dout ||
          sif_a.sram_bs_n !== cap_bs || sif_a.sram_d_oe !== 1'b1)
        stable_ok = 1'b0;
      ce_cnt++;
      if (!sif_a.sram_we_n) we_cnt++;
    end else if (in_win) begin
      exp_t e;
      in_win = 1'b0;
      n_writes++;
      last_addr = cap_addr;
      last_dout = cap_dout;
      last_bs   = cap_bs;
      check("ce_low_cycles", 64'(ce_cnt), 64'd5);
      check("we_low_cycles", 64'(we_cnt), 64'd3);
      check("bus_stable", 64'(stable_ok), 64'd1);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_write: got unexpected write addr 0x%0h data 0x%0h required none", cap_addr, cap_dout);
      end else begin
        e = sb.pop_front();
        check("sb_addr", 64'(cap_addr), 64'(e.addr));
        check("sb_data", 64'(cap_dout & lanes(e.bs)), 64'(e.data & lanes(e.bs)));
        check("sb_bs_n", 64'(cap_bs), 64'(e.bs));
      end
    end
  end

  // full on dut_b must rise exactly with its fourth completed write.
  bit full_bad = 1'b0;
  always @(negedge clk) begin
    if (!reset && ((ww_b == 19'd4) != full_b)) full_bad = 1'b1;
  end

  // ---------------- drivers (all called at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b, input bit fl);
    int t;
    t = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!ready_a && t < 200) begin
      @(negedge clk);
      stall_cnt++;
      t++;
    end
    if (!ready_a) begin
      check("byte_ready_timeout", 64'(ready_a), 64'd1);
    end else begin
      flush = fl;
      m_accept(b);
      if (fl) m_flush();
    end
    @(negedge clk);
    byte_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    m_flush();
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    byte_valid = 1'b0;
    flush      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    sb.delete();
    m_cnt  = 0;
    m_word = '0;
    m_addr = 0;
  endtask

  task automatic wait_idle();
    int t, run;
    t = 0;
    run = 0;
    while (run < 8 && t < 400) begin
      @(negedge clk);
      t++;
      if (sb.size() == 0 && sif_a.sram_ce_n) run++;
      else run = 0;
    end
    if (run < 8) check("idle_timeout", 64'(sb.size()), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          n;
    logic [31:0] bytes;
    bit          fl_last;
    bit          fl_after;
    logic [31:0] exp_d;
    logic [3:0]  exp_bs;
  } vec_t;

  vec_t vt[5];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int w0;
    logic [31:0] bb;
    reset      = 1'b1;
    byte_valid = 1'b0;
    flush      = 1'b0;
    byte_data  = '0;

    vt[0] = '{4, 32'h44332211, 1'b0, 1'b0, 32'h44332211, 4'b0000};
    vt[1] = '{2, 32'h0000BBAA, 1'b0, 1'b1, 32'h0000BBAA, 4'b1100};
    vt[2] = '{3, 32'h00030201, 1'b1, 1'b0, 32'h00030201, 4'b1000};
    vt[3] = '{1, 32'h0000005A, 1'b0, 1'b1, 32'h0000005A, 4'b1110};
    vt[4] = '{4, 32'hEFBEADDE, 1'b0, 1'b0, 32'hEFBEADDE, 4'b0000};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ce_n",  64'(sif_a.sram_ce_n), 64'd1);
    check("rst_we_n",  64'(sif_a.sram_we_n), 64'd1);
    check("rst_oe_n",  64'(sif_a.sram_oe_n), 64'd1);
    check("rst_bs_n",  64'(sif_a.sram_bs_n), 64'hF);
    check("rst_d_oe",  64'(sif_a.sram_d_oe), 64'd0);
    check("rst_dout",  64'(sif_a.sram_dout), 64'd0);
    check("rst_addr",  64'(sif_a.sram_addr), 64'd0);
    check("rst_full",  64'(full_a), 64'd0);
    check("rst_words", 64'(ww_a), 64'd0);
    check("rst_ready", 64'(ready_a), 64'd1);
    reset = 1'b0;

    // Table: one word (full or partial) per entry from a clean reset.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      w0 = n_writes;
      bb = vt[i].bytes;
      for (int k = 0; k < vt[i].n; k++)
        send_byte(bb[8*k +: 8], vt[i].fl_last && (k == vt[i].n - 1));
      if (vt[i].fl_after) flush_pulse();
      wait_idle();
      check("vec_writes", 64'(n_writes - w0), 64'd1);
      check("vec_dout",   64'(last_dout & lanes(vt[i].exp_bs)), 64'(vt[i].exp_d));
      check("vec_bs_n",   64'(last_bs), 64'(vt[i].exp_bs));
      check("vec_addr",   64'(last_addr), 64'd0);
      check("vec_words",  64'(ww_a), 64'd1);
      check("vec_next_addr", 64'(sif_a.sram_addr), 64'd1);
    end

    // Flush with nothing packed: no SRAM activity.
    w0 = n_writes;
    flush_pulse();
    repeat (10) @(negedge clk);
    check("flush0_writes", 64'(n_writes - w0), 64'd0);
    check("flush0_words",  64'(ww_a), 64'd1);
    check("flush0_ce_n",   64'(sif_a.sram_ce_n), 64'd1);

    // Streaming 40 bytes with byte_valid held high.
    do_reset();
    w0 = n_writes;
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) send_byte(8'(i), 1'b0);
    wait_idle();
    check("stream_writes", 64'(n_writes - w0), 64'd10);
    check("stream_last_addr", 64'(last_addr), 64'd9);
    check("stream_last_data", 64'(last_dout), 64'h27262524);
    check("stream_words", 64'(ww_a), 64'd10);
    check("stream_addr", 64'(sif_a.sram_addr), 64'd10);
    check("stream_stalled", 64'(stall_cnt != 0), 64'd1);

    // Full on dut_b (LAST_ADDR = 3) with 20 bytes streamed.
    do_reset();
    full_bad = 1'b0;
    for (int i = 0; i < 20; i++) send_byte(8'(8'h80 + i), 1'b0);
    wait_idle();
    check("full_a_words", 64'(ww_a), 64'd5);
    check("full_b_full",  64'(full_b), 64'd1);
    check("full_b_ready", 64'(ready_b), 64'd0);
    check("full_b_addr",  64'(sif_b.sram_addr), 64'd3);
    check("full_b_words", 64'(ww_b), 64'd4);
    send_byte(8'h55, 1'b1);
    repeat (10) @(negedge clk);
    check("full_b_flush_ign", 64'(ww_b), 64'd4);
    check("full_b_ce_n", 64'(sif_b.sram_ce_n), 64'd1);
    check("full_b_timing", 64'(full_bad), 64'd0);
    wait_idle();

    // Reset in the middle of the second word's WE-low phase.
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 1'b0);
    wait_idle();
    check("mid_pre_words", 64'(ww_a), 64'd1);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h20 + i), 1'b0);
    begin
      int t;
      t = 0;
      while (sif_a.sram_we_n && t < 30) begin
        @(negedge clk);
        t++;
      end
    end
    check("mid_we_seen", 64'(sif_a.sram_we_n), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_we_n",  64'(sif_a.sram_we_n), 64'd1);
    check("mid_ce_n",  64'(sif_a.sram_ce_n), 64'd1);
    check("mid_d_oe",  64'(sif_a.sram_d_oe), 64'd0);
    check("mid_addr",  64'(sif_a.sram_addr), 64'd0);
    check("mid_words", 64'(ww_a), 64'd0);
    reset = 1'b0;
    sb.delete();
    m_cnt  = 0;
    m_word = '0;
    m_addr = 0;
    w0 = n_writes;
    repeat (12) @(negedge clk);
    check("mid_no_write", 64'(n_writes - w0), 64'd0);
    check("mid_words_after", 64'(ww_a), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
